// File: rtl/adder_pkg.sv
// Shared definitions for the chunked multi-cycle adder: FSM states and the
// parameter-legality check used at elaboration.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } adder_state_t;

  // WIDTH must be a positive multiple of a positive CHUNK.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    if (width < 1 || chunk < 1) begin
      return 1'b0;
    end
    return (width % chunk) == 0;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB so
// the top can form signed overflow from the last slice.
module chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(ci);
  assign s    = full[CHUNK-1:0];
  assign co   = full[CHUNK];
  // Sum bit = a ^ b ^ carry-in at the MSB, so the incoming carry falls out directly.
  assign cm   = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle A + B + CI adder: one CHUNK-bit slice per clock with a
// registered ripple carry, START/BUSY/DONE handshake, carry and overflow flags.
module chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  generate
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
      $error("chunk_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  adder_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] s_q,     s_d;
  logic             c_q,     c_d;
  logic             v_q,     v_d;
  logic             done_q,  done_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             chunk_co;
  logic             chunk_cm;

  // One slice shared by all chunks; the counter steers which bits it sees.
  assign a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[cnt_q*CHUNK +: CHUNK];

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry_q),
    .s  (sum_chunk),
    .co (chunk_co),
    .cm (chunk_cm)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          carry_d = CI;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d[cnt_q*CHUNK +: CHUNK] = sum_chunk;
        carry_d = chunk_co;
        if (cnt_q == LAST_CNT) begin
          // Outputs take the full result in one step, never a partial sum.
          s_d     = res_d;
          c_d     = chunk_co;
          v_d     = chunk_co ^ chunk_cm;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = (state_q == RUN);
  assign DONE = done_q;
  assign S    = s_q;
  assign C    = c_q;
  assign V    = v_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Randomized bench for chunk_adder (16/4 and 1/1 configurations) against an
// arithmetic reference model of A + B + CI with carry and signed overflow.
module tb_chunk_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        c;
  logic        v;

  logic        rst1;
  logic        start1;
  logic [0:0]  a1;
  logic [0:0]  b1;
  logic        ci1;
  logic        busy1;
  logic        done1;
  logic [0:0]  s1;
  logic        c1;
  logic        v1;

  int vectors = 0;
  int errors  = 0;

  // Outputs the DUT is expected to be holding right now.
  logic [15:0] exp_s;
  logic        exp_c;
  logic        exp_v;

  chunk_adder #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .A     (a),
    .B     (b),
    .CI    (ci),
    .BUSY  (busy),
    .DONE  (done),
    .S     (s),
    .C     (c),
    .V     (v)
  );

  chunk_adder #(
    .WIDTH (1),
    .CHUNK (1)
  ) dut1 (
    .CLK   (clk),
    .RST   (rst1),
    .START (start1),
    .A     (a1),
    .B     (b1),
    .CI    (ci1),
    .BUSY  (busy1),
    .DONE  (done1),
    .S     (s1),
    .C     (c1),
    .V     (v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {V, C, S[15:0]} from plain arithmetic on the operands.
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin);
    int unsigned sum;
    logic [15:0] sm;
    logic        cy;
    logic        ov;
    sum = x + y + cin;
    sm  = sum[15:0];
    cy  = sum[16];
    ov  = (x[15] == y[15]) && (sm[15] != x[15]);
    return {ov, cy, sm};
  endfunction

  function automatic logic [2:0] ref1(input logic x, input logic y, input logic cin);
    int unsigned sum;
    logic sm;
    logic ov;
    sum = x + y + cin;
    sm  = sum[0];
    ov  = (x == y) && (sm != x);
    return {ov, sum[1], sm};
  endfunction

  // Entered at a negedge with the DUT idle (or in its DONE cycle); leaves at
  // the negedge of the DONE cycle with START low.
  task automatic op16(input logic [15:0] oa, input logic [15:0] ob, input logic oci,
                      input bit poke);
    logic [17:0] r;
    r     = ref16(oa, ob, oci);
    start = 1'b1;
    a     = oa;
    b     = ob;
    ci    = oci;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("busy_run", busy, 1);
      check("done_early", done, 0);
      check("s_held", s, exp_s);
      check("c_held", c, exp_c);
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      if (poke && k == 1) begin
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    exp_s = r[15:0];
    exp_c = r[16];
    exp_v = r[17];
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("sum", s, exp_s);
    check("carry", c, exp_c);
    check("overflow", v, exp_v);
  endtask

  task automatic idle16(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("done_idle", done, 0);
      check("busy_idle", busy, 0);
      check("s_idle", s, exp_s);
    end
  endtask

  task automatic op1(input logic oa, input logic ob, input logic oci);
    logic [2:0] r;
    r      = ref1(oa, ob, oci);
    start1 = 1'b1;
    a1     = oa;
    b1     = ob;
    ci1    = oci;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", busy1, 1);
    check("w1_done_early", done1, 0);
    @(posedge clk);
    @(negedge clk);
    check("w1_done", done1, 1);
    check("w1_busy_done", busy1, 0);
    check("w1_sum", s1, r[0]);
    check("w1_carry", c1, r[1]);
    check("w1_overflow", v1, r[2]);
    @(posedge clk);
    @(negedge clk);
    check("w1_done_once", done1, 0);
  endtask

  initial begin
    rst    = 1'b1;
    rst1   = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    ci     = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    ci1    = 1'b0;
    exp_s  = '0;
    exp_c  = 1'b0;
    exp_v  = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_c", c, 0);
    check("rst_v", v, 0);
    check("rst_w1_s", s1, 0);
    rst  = 1'b0;
    rst1 = 1'b0;
    idle16(1);

    // Directed corner cases.
    op16(16'h0001, 16'h0001, 1'b0, 1'b0); idle16(1);
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0); idle16(1);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0); idle16(1);
    op16(16'h8000, 16'h8000, 1'b1, 1'b0); idle16(1);

    // START during RUN ignored, then START held in the DONE cycle.
    op16(16'h1234, 16'h1111, 1'b0, 1'b1);
    op16(16'h00FF, 16'h0001, 1'b0, 1'b0);
    idle16(1);

    // Reset in the middle of an operation, with non-zero outputs beforehand.
    op16(16'h8000, 16'h8000, 1'b1, 1'b0); idle16(1);
    start = 1'b1;
    a     = 16'h0F0F;
    b     = 16'h0101;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s", s, 0);
    check("mid_rst_c", c, 0);
    check("mid_rst_v", v, 0);
    @(negedge clk);
    rst   = 1'b0;
    exp_s = '0;
    exp_c = 1'b0;
    exp_v = 1'b0;
    idle16(10);

    // Randomized operations, some back-to-back, some with a stray START.
    for (int i = 0; i < 40; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle16(1);
    end
    idle16(1);

    // Degenerate single-bit configuration.
    op1(1'b0, 1'b0, 1'b0);
    op1(1'b1, 1'b0, 1'b0);
    op1(1'b0, 1'b1, 1'b0);
    op1(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      op1(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
